// File: rtl/fetch_defs.sv
// Shared fetch-stage definitions: default widths, FSM encodings and last ROM address.
// Optional behaviour is selected with the FETCH_WRAP_EN macro in instruction_fetch.
package fetch_defs;

  localparam int DEF_ADDR_W = 3;
  localparam int DEF_INST_W = 16;

  localparam logic [DEF_ADDR_W-1:0] LAST_ADDR = '1;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    DONE  = 2'd1,
    HALT  = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/instruction_fetch_if.sv
// Fetch-to-decode handshake bundle: registered instruction, its pc, valid/ready.
// The master modport is the fetch stage, the slave modport is decode.
interface instruction_fetch_if
  import fetch_defs::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int INST_W = DEF_INST_W
);

  logic [INST_W-1:0] inst_out;
  logic [ADDR_W-1:0] inst_pc;
  logic              inst_valid;
  logic              inst_ready;

  modport master (
    output inst_out,
    output inst_pc,
    output inst_valid,
    input  inst_ready
  );

  modport slave (
    input  inst_out,
    input  inst_pc,
    input  inst_valid,
    output inst_ready
  );

endinterface

// File: rtl/fetch_pc.sv
// Program counter: load has priority over increment, otherwise hold.
// Arithmetic wraps modulo 2**ADDR_W; last_o flags the final ROM word.
module fetch_pc #(
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic [ADDR_W-1:0] load_addr_i,
  input  logic              inc_i,
  output logic [ADDR_W-1:0] pc_o,
  output logic              last_o
);

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_d;

  always_comb begin
    pc_d = pc_q;
    if (load_i)
      pc_d = load_addr_i;
    else if (inc_i)
      pc_d = pc_q + ADDR_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      pc_q <= '0;
    else
      pc_q <= pc_d;
  end

  assign pc_o   = pc_q;
  assign last_o = (pc_q == {ADDR_W{1'b1}});

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: pc, ROM address, registered instruction on a valid/ready handshake.
// FETCH_WRAP_EN: pc wraps after the last word and the stage never halts.
module instruction_fetch
  import fetch_defs::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int INST_W = DEF_INST_W
) (
  input  logic                clk,
  input  logic                rst,
  output logic [ADDR_W-1:0]   rom_addr,
  input  logic [INST_W-1:0]   rom_inst,
  instruction_fetch_if.master dec,
  input  logic                redirect_en,
  input  logic [ADDR_W-1:0]   redirect_addr,
  output logic                halted
);

  fetch_state_e      state_q, state_d;
  logic [INST_W-1:0] inst_out_q, inst_out_d;
  logic [ADDR_W-1:0] inst_pc_q, inst_pc_d;
  logic              valid_q, valid_d;
  logic              halted_q, halted_d;

  logic [ADDR_W-1:0] pc;
  logic              pc_last;
  logic              pc_load;
  logic              pc_inc;
  logic              accept;
  logic              slot_free;

  fetch_pc #(
    .ADDR_W (ADDR_W)
  ) u_pc (
    .clk         (clk),
    .rst         (rst),
    .load_i      (pc_load),
    .load_addr_i (redirect_addr),
    .inc_i       (pc_inc),
    .pc_o        (pc),
    .last_o      (pc_last)
  );

  assign accept    = valid_q & dec.inst_ready;
  assign slot_free = ~valid_q | accept;

  always_comb begin
    state_d    = state_q;
    inst_out_d = inst_out_q;
    inst_pc_d  = inst_pc_q;
    valid_d    = valid_q;
    halted_d   = halted_q;
    pc_load    = 1'b0;
    pc_inc     = 1'b0;
    // Redirect flushes the output register and beats any capture/accept.
    if (redirect_en) begin
      pc_load  = 1'b1;
      valid_d  = 1'b0;
      halted_d = 1'b0;
      state_d  = FETCH;
    end else begin
      case (state_q)
        FETCH: begin
          if (slot_free) begin
            inst_out_d = rom_inst;
            inst_pc_d  = pc;
            valid_d    = 1'b1;
`ifdef FETCH_WRAP_EN
            pc_inc     = 1'b1;
`else
            if (pc_last)
              state_d  = DONE;
            else
              pc_inc   = 1'b1;
`endif
          end
        end
        DONE: begin
          if (accept) begin
            valid_d  = 1'b0;
            halted_d = 1'b1;
            state_d  = HALT;
          end
        end
        HALT: begin
          valid_d  = 1'b0;
          halted_d = 1'b1;
        end
        default: begin
          state_d = FETCH;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= FETCH;
      inst_out_q <= '0;
      inst_pc_q  <= '0;
      valid_q    <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      inst_out_q <= inst_out_d;
      inst_pc_q  <= inst_pc_d;
      valid_q    <= valid_d;
      halted_q   <= halted_d;
    end
  end

  assign rom_addr       = pc;
  assign dec.inst_out   = inst_out_q;
  assign dec.inst_pc    = inst_pc_q;
  assign dec.inst_valid = valid_q;
  assign halted         = halted_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch with ROM word[i] = 16'hA000 + i.
// Build with +define+FETCH_WRAP_EN to exercise the wrapping variant.
module tb_instruction_fetch;
  import fetch_defs::*;

  localparam int AW = 3;
  localparam int IW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] rom_addr;
  logic [IW-1:0] rom_inst;
  logic          ready;
  logic          redirect_en;
  logic [AW-1:0] redirect_addr;
  logic          halted;

  int checks = 0;
  int errors = 0;
  int pops   = 0;

  logic [IW+AW-1:0] exp_q[$];

  instruction_fetch_if #(.ADDR_W(AW), .INST_W(IW)) dec_if ();

  instruction_fetch #(.ADDR_W(AW), .INST_W(IW)) dut (
    .clk           (clk),
    .rst           (rst),
    .rom_addr      (rom_addr),
    .rom_inst      (rom_inst),
    .dec           (dec_if),
    .redirect_en   (redirect_en),
    .redirect_addr (redirect_addr),
    .halted        (halted)
  );

  always #5 clk = ~clk;

  assign rom_inst        = 16'hA000 + IW'(rom_addr);
  assign dec_if.inst_ready = ready;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push(input int addr);
    logic [AW-1:0] a;
    a = AW'(addr);
    exp_q.push_back({16'hA000 + IW'(a), a});
  endtask

  // Monitor: every accepted word must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst && dec_if.inst_valid && ready && !redirect_en) begin
      pops++;
      if (exp_q.size() == 0) begin
        chk("unexpected_word", {13'd0, dec_if.inst_out, dec_if.inst_pc}, 32'hFFFF_FFFF);
      end else begin
        chk("accepted_word", {13'd0, dec_if.inst_out, dec_if.inst_pc},
            {13'd0, exp_q.pop_front()});
      end
    end
`ifdef FETCH_WRAP_EN
    if (!rst)
      chk("halted_never", {31'd0, halted}, 32'd0);
`endif
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic redirect(input int addr);
    redirect_en   = 1'b1;
    redirect_addr = AW'(addr);
    step();
    redirect_en   = 1'b0;
  endtask

  task automatic wait_valid(input int n);
    for (int i = 0; i < n; i++) begin
      if (dec_if.inst_valid) break;
      step();
    end
    chk("valid_timeout", {31'd0, dec_if.inst_valid}, 32'd1);
  endtask

  task automatic accept_one();
    wait_valid(20);
    ready = 1'b1;
    step();
    ready = 1'b0;
  endtask

  task automatic wait_halted(input int n);
    for (int i = 0; i < n; i++) begin
      if (halted) break;
      step();
    end
    chk("halt_timeout", {31'd0, halted}, 32'd1);
  endtask

  initial begin
    int p0;
    rst           = 1'b1;
    ready         = 1'b0;
    redirect_en   = 1'b0;
    redirect_addr = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid",   {31'd0, dec_if.inst_valid}, 32'd0);
    chk("rst_inst",    {16'd0, dec_if.inst_out},   32'd0);
    chk("rst_pc",      {29'd0, dec_if.inst_pc},    32'd0);
    chk("rst_halted",  {31'd0, halted},            32'd0);
    chk("rst_romaddr", {29'd0, rom_addr},          32'd0);

`ifdef FETCH_WRAP_EN
    for (int i = 0; i < 9; i++) push(i);
    p0    = pops;
    rst   = 1'b0;
    ready = 1'b1;
    repeat (10) step();
    ready = 1'b0;
    chk("wrap_pops", pops - p0, 32'd9);
    chk("wrap_inst", {16'd0, dec_if.inst_out}, 32'hA001);
    chk("wrap_pc",   {29'd0, dec_if.inst_pc},  32'd1);
    chk("wrap_valid", {31'd0, dec_if.inst_valid}, 32'd1);
`else
    // 1: full stream at one word per cycle, then halt.
    for (int i = 0; i < 8; i++) push(i);
    p0    = pops;
    rst   = 1'b0;
    ready = 1'b1;
    repeat (9) step();
    chk("t1_pops",   pops - p0,                   32'd8);
    chk("t1_halted", {31'd0, halted},             32'd1);
    chk("t1_valid",  {31'd0, dec_if.inst_valid},  32'd0);
    chk("t1_romaddr", {29'd0, rom_addr},          32'd7);
    ready = 1'b0;

    // 4 + 2: restart from HALT, then stall on A002.
    for (int i = 0; i < 8; i++) push(i);
    redirect(0);
    chk("t4_halted", {31'd0, halted},            32'd0);
    chk("t4_valid",  {31'd0, dec_if.inst_valid}, 32'd0);
    accept_one();
    accept_one();
    for (int i = 0; i < 3; i++) begin
      chk("t2_stall_inst", {16'd0, dec_if.inst_out}, 32'hA002);
      chk("t2_stall_pc",   {29'd0, dec_if.inst_pc},  32'd2);
      chk("t2_stall_rom",  {29'd0, rom_addr},        32'd3);
      step();
    end
    ready = 1'b1;
    step();
    chk("t2_next_inst", {16'd0, dec_if.inst_out}, 32'hA003);
    chk("t2_next_pc",   {29'd0, dec_if.inst_pc},  32'd3);
    wait_halted(20);
    ready = 1'b0;
    chk("t2_sb_empty", exp_q.size(), 32'd0);

    // 3: redirect to 5 while A001 is pending.
    redirect(1);
    wait_valid(5);
    chk("t3_pend_inst", {16'd0, dec_if.inst_out}, 32'hA001);
    redirect(5);
    chk("t3_flush", {31'd0, dec_if.inst_valid}, 32'd0);
    for (int i = 5; i < 8; i++) push(i);
    ready = 1'b1;
    step();
    chk("t3_tgt_inst", {16'd0, dec_if.inst_out}, 32'hA005);
    chk("t3_tgt_pc",   {29'd0, dec_if.inst_pc},  32'd5);
    wait_halted(20);
    ready = 1'b0;
    chk("t3_sb_empty", exp_q.size(), 32'd0);

    // 5: asynchronous reset in the middle of a stall at pc=4.
    redirect(0);
    for (int i = 0; i < 3; i++) push(i);
    for (int i = 0; i < 3; i++) accept_one();
    chk("t5_stall_rom", {29'd0, rom_addr}, 32'd4);
    #2;
    rst = 1'b1;
    #1;
    chk("t5_valid",   {31'd0, dec_if.inst_valid}, 32'd0);
    chk("t5_romaddr", {29'd0, rom_addr},          32'd0);
    chk("t5_inst",    {16'd0, dec_if.inst_out},   32'd0);
    step();
    rst = 1'b0;
`endif
    step();
    chk("final_sb_empty", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
